// File: rtl/subtractor_32bit_seq.sv
`default_nettype none
// ============================================================================
// Module      : subtractor_32bit_seq
// Description : Multi-cycle 32-bit subtractor (inA - inB - inBorrow) that
//               reuses one 16-bit add slice over two cycles, low half first.
//               Valid/ready handshake on both operand and result sides.
//               Optional build macro SUBTRACTOR_SAT_EN selects saturating
//               unsigned mode (result forced to zero on underflow).
// Revision    : 1.0 - initial release
// ============================================================================
module subtractor_32bit_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inValid,
  output logic        outReady,
  input  logic [31:0] inA,
  input  logic [31:0] inB,
  input  logic        inBorrow,
  output logic        outValid,
  input  logic        inReady,
  output logic [31:0] outDiff,
  output logic        outBorrow
);

  localparam int unsigned C_SLICE_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  logic [31:0]          r_a;
  logic [31:0]          r_b;
  logic                 r_cin;     // slice carry-in for the low half (~inBorrow)
  logic                 r_carry;   // low-slice carry-out feeding the high half
  logic [C_SLICE_W-1:0] r_lo;      // low half held until the full result commits
  logic [31:0]          r_diff;
  logic                 r_borrow;
  logic                 r_valid;

  logic [C_SLICE_W-1:0] w_x;
  logic [C_SLICE_W-1:0] w_y;
  logic                 w_c;
  logic [C_SLICE_W:0]   w_sum;
  logic                 w_borrow;
  logic [31:0]          w_result;

  // Shared slice: X + ~Y + c, operand halves selected by the current phase
  always_comb begin
    w_x = r_a[C_SLICE_W-1:0];
    w_y = r_b[C_SLICE_W-1:0];
    w_c = r_cin;
    if (r_state == S_HIGH) begin
      w_x = r_a[31:C_SLICE_W];
      w_y = r_b[31:C_SLICE_W];
      w_c = r_carry;
    end
    w_sum    = {1'b0, w_x} + {1'b0, ~w_y} + {{C_SLICE_W{1'b0}}, w_c};
    w_borrow = ~w_sum[C_SLICE_W];
`ifdef SUBTRACTOR_SAT_EN
    w_result = w_borrow ? 32'd0 : {w_sum[C_SLICE_W-1:0], r_lo};
`else
    w_result = {w_sum[C_SLICE_W-1:0], r_lo};
`endif
  end

  // Control FSM and datapath registers; outputs only change when HIGH commits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_cin    <= 1'b0;
      r_carry  <= 1'b0;
      r_lo     <= '0;
      r_diff   <= 32'd0;
      r_borrow <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (inValid) begin
            r_a     <= inA;
            r_b     <= inB;
            r_cin   <= ~inBorrow;
            r_state <= S_LOW;
          end
        end
        S_LOW: begin
          r_lo    <= w_sum[C_SLICE_W-1:0];
          r_carry <= w_sum[C_SLICE_W];
          r_state <= S_HIGH;
        end
        S_HIGH: begin
          r_diff   <= w_result;
          r_borrow <= w_borrow;
          r_valid  <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          if (inReady) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign outReady  = (r_state == S_IDLE);
  assign outValid  = r_valid;
  assign outDiff   = r_diff;
  assign outBorrow = r_borrow;

endmodule
`default_nettype wire

// File: tb/tb_subtractor_32bit_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_subtractor_32bit_seq
// Description : Self-checking bench for subtractor_32bit_seq. A behavioural
//               model (plain 64-bit arithmetic) predicts each accepted
//               operation; a compare process checks every valid output cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_subtractor_32bit_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inValid = 1'b0;
  logic        outReady;
  logic [31:0] inA = 32'd0;
  logic [31:0] inB = 32'd0;
  logic        inBorrow = 1'b0;
  logic        outValid;
  logic        inReady = 1'b0;
  logic [31:0] outDiff;
  logic        outBorrow;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int pops     = 0;

  typedef struct packed {
    logic [31:0] diff;
    logic        borrow;
  } res_t;

  res_t exp_q[$];
  int   acc_cycles[$];

  always #5 clk = ~clk;

  subtractor_32bit_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inValid   (inValid),
    .outReady  (outReady),
    .inA       (inA),
    .inB       (inB),
    .inBorrow  (inBorrow),
    .outValid  (outValid),
    .inReady   (inReady),
    .outDiff   (outDiff),
    .outBorrow (outBorrow)
  );

  // Reference: full-precision unsigned subtraction
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic bor);
    res_t r;
    longint unsigned have;
    longint unsigned need;
    have     = {32'd0, a};
    need     = {32'd0, b} + {63'd0, bor};
    r.borrow = (need > have);
    r.diff   = a - b - {31'd0, bor};
`ifdef SUBTRACTOR_SAT_EN
    if (r.borrow) r.diff = 32'd0;
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%09h expected 0x%09h", name, act, exp);
    end
  endtask

  // Handshake monitor: enqueue predictions on acceptance, retire on output handshake
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (rst_n && inValid && outReady) begin
      exp_q.push_back(model(inA, inB, inBorrow));
      acc_cycles.push_back(cycle);
    end
    if (rst_n && outValid && inReady && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      pops <= pops + 1;
    end
  end

  always @(negedge rst_n) exp_q.delete();

  // Compare process: every cycle outside reset
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_valid_exclusive", {32'd0, outReady & outValid}, 33'd0);
      if (outValid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got diff=0x%08h borrow=%0d expected no valid result", outDiff, outBorrow);
        end else begin
          check("scoreboard_result", {outBorrow, outDiff}, {exp_q[0].borrow, exp_q[0].diff});
        end
      end
    end
  end

  // One directed operation with literal expectation, optional output stall
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bor,
                        input logic [31:0] lit_diff, input logic lit_bor,
                        input int stall, input string name);
    res_t m;
    logic [31:0] want;
    want = lit_diff;
`ifdef SUBTRACTOR_SAT_EN
    if (lit_bor) want = 32'd0;
`endif
    m = model(a, b, bor);
    check({name, "_model"}, {m.borrow, m.diff}, {lit_bor, want});
    inA = a; inB = b; inBorrow = bor; inValid = 1'b1; inReady = 1'b0;
    @(posedge clk); #1;                       // E0
    inValid = 1'b0;
    check({name, "_accepted"}, {32'd0, outReady}, 33'd0);
    inA = ~a; inB = a ^ 32'h5A5A_A5A5; inBorrow = ~bor;   // must not disturb result
    @(posedge clk); #1;                       // E0+1
    check({name, "_not_yet_valid"}, {32'd0, outValid}, 33'd0);
    @(posedge clk); #1;                       // E0+2
    check({name, "_latency"}, {32'd0, outValid}, 33'd1);
    check({name, "_result"}, {outBorrow, outDiff}, {lit_bor, want});
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check({name, "_stall_valid"}, {32'd0, outValid}, 33'd1);
      check({name, "_stall_ready"}, {32'd0, outReady}, 33'd0);
      check({name, "_stall_data"}, {outBorrow, outDiff}, {lit_bor, want});
    end
    inReady = 1'b1;
    @(posedge clk); #1;
    inReady = 1'b0;
    check({name, "_drop_valid"}, {32'd0, outValid}, 33'd0);
    check({name, "_ready_back"}, {32'd0, outReady}, 33'd1);
  endtask

  logic [31:0] tp_a [3];
  logic [31:0] tp_b [3];
  logic        tp_c [3];
  logic [31:0] tp_d [3];
  logic        tp_o [3];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int idx;
    int start;
    int pops0;
    res_t m;

    // Reset state
    #2;
    check("reset_ready", {32'd0, outReady}, 33'd1);
    check("reset_valid", {32'd0, outValid}, 33'd0);
    check("reset_out", {outBorrow, outDiff}, 33'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(32'd5,          32'd3,          1'b0, 32'h0000_0002, 1'b0, 0, "basic");
    run_op(32'h0001_0000,  32'h0000_0001,  1'b0, 32'h0000_FFFF, 1'b0, 2, "cross_slice");
    run_op(32'h0000_0000,  32'h0000_0000,  1'b1, 32'hFFFF_FFFF, 1'b1, 0, "borrow_in_only");
    run_op(32'h0000_0000,  32'h0000_0001,  1'b0, 32'hFFFF_FFFF, 1'b1, 5, "underflow_bp");
    run_op(32'hDEAD_BEEF,  32'hDEAD_BEEF,  1'b0, 32'h0000_0000, 1'b0, 1, "equal");
    run_op(32'h8000_0000,  32'h7FFF_FFFF,  1'b1, 32'h0000_0000, 1'b0, 0, "exact_zero_bin");

    // Reset in the middle of HIGH with a new request pending
    inA = 32'h1234_5678; inB = 32'h0000_0001; inBorrow = 1'b0; inValid = 1'b1;
    @(posedge clk); #1;                       // now in LOW
    inValid = 1'b0;
    @(posedge clk); #1;                       // now in HIGH
    inValid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", {32'd0, outValid}, 33'd0);
    check("midrst_ready", {32'd0, outReady}, 33'd1);
    check("midrst_out", {outBorrow, outDiff}, 33'd0);
    inValid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("post_reset_no_stale", {32'd0, outValid}, 33'd0);
    end

    // Throughput: request held high, sink always ready
    tp_a[0] = 32'hFFFF_FFFF; tp_b[0] = 32'h7FFF_FFFF; tp_c[0] = 1'b0; tp_d[0] = 32'h8000_0000; tp_o[0] = 1'b0;
    tp_a[1] = 32'h0000_0010; tp_b[1] = 32'h0000_0020; tp_c[1] = 1'b0; tp_d[1] = 32'hFFFF_FFF0; tp_o[1] = 1'b1;
    tp_a[2] = 32'h0000_0100; tp_b[2] = 32'h0000_00FF; tp_c[2] = 1'b1; tp_d[2] = 32'h0000_0000; tp_o[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m = model(tp_a[k], tp_b[k], tp_c[k]);
`ifdef SUBTRACTOR_SAT_EN
      check("tp_model", {m.borrow, m.diff}, {tp_o[k], tp_o[k] ? 32'd0 : tp_d[k]});
`else
      check("tp_model", {m.borrow, m.diff}, {tp_o[k], tp_d[k]});
`endif
    end
    start = acc_cycles.size();
    pops0 = pops;
    idx = 0;
    inReady = 1'b1;
    inA = tp_a[0]; inB = tp_b[0]; inBorrow = tp_c[0]; inValid = 1'b1;
    for (int t = 0; t < 30 && idx < 3; t++) begin
      @(posedge clk); #1;
      if (acc_cycles.size() > start + idx) begin
        idx++;
        if (idx < 3) begin
          inA = tp_a[idx]; inB = tp_b[idx]; inBorrow = tp_c[idx];
        end else begin
          inValid = 1'b0;
        end
      end
    end
    inValid = 1'b0;
    check("tp_accept_count", {1'b0, 32'(idx)}, 33'd3);
    if (idx == 3) begin
      check("tp_interval_0_1", {1'b0, 32'(acc_cycles[start+1] - acc_cycles[start])}, 33'd4);
      check("tp_interval_1_2", {1'b0, 32'(acc_cycles[start+2] - acc_cycles[start+1])}, 33'd4);
    end
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) begin
      @(posedge clk); #1;
    end
    check("tp_drained", {1'b0, 32'(exp_q.size())}, 33'd0);
    check("tp_results_out", {1'b0, 32'(pops - pops0)}, 33'd3);
    inReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/subtractor_32bit_seq.md
# subtractor_32bit_seq

Multi-cycle 32-bit subtractor computing inA − inB − inBorrow. It reuses a single 16-bit add slice over two cycles, low half first, then high half, with the B operand inverted and the borrow carried between halves. The block sits beside the combinational 32-bit adder in the arithmetic library, serving area-constrained datapaths that tolerate latency. It uses a valid/ready handshake on both input and output.

## Interface
Parameters: none (width fixed at 32, slice width fixed at 16).

Ports:
- clk  input  1  single clock, rising-edge active
- rst_n  input  1  reset, asynchronous, active-low
- inValid  input  1  operand request valid
- outReady  output  1  block can accept operands
- inA  input  32  minuend
- inB  input  32  subtrahend
- inBorrow  input  1  borrow-in (1 = subtract one extra)
- outValid  output  1  result valid
- inReady  input  1  downstream accepts result
- outDiff  output  32  difference, mod 2^32
- outBorrow  output  1  final borrow-out (1 = unsigned underflow)

## Operation
- Arithmetic: the slice computes X + ~Y + c. The first carry-in is ~inBorrow. The carry between halves is the low-slice carry-out. outBorrow = ~(high-slice carry-out). All operations are unsigned mod 2^32.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE: outReady=1. If inValid=1, capture inA, inB, and inBorrow into internal registers and move to LOW. Otherwise stay in IDLE.
  - LOW: compute the low 16 bits from captured operands, register diff[15:0] and the internal carry, then move to HIGH.
  - HIGH: compute the high 16 bits using the registered carry, register diff[31:16] and outBorrow, then move to DONE.
  - DONE: outValid=1. If inReady=1, return to IDLE. Otherwise hold.
- outReady is 1 only in IDLE. outValid is 1 only in DONE.
- Operands are captured at acceptance. Changes on inA, inB, or inBorrow after acceptance have no effect on the result.
- While outValid=1 and inReady=0, outDiff and outBorrow are held stable.
- After the output handshake, outDiff and outBorrow keep the last result until the next HIGH completes. The value is only meaningful while outValid=1.
- inReady is ignored outside DONE. inValid is ignored outside IDLE.
- Reset values: state=IDLE, outReady=1, outValid=0, outDiff=0x00000000, outBorrow=0, all internal registers 0.
- Reset asserted mid-operation (LOW, HIGH, or DONE) discards the operation immediately and asynchronously. No result is emitted after reset deasserts.

## Timing
- Input handshake occurs on the rising edge where inValid=1 and outReady=1 (edge E0).
- Edge E0+1 completes LOW. Edge E0+2 completes HIGH and sets outValid=1.
- Latency: outValid is first high in the cycle after E0+2, so two cycles from acceptance to result.
- Output handshake occurs on the rising edge in DONE with inReady=1. outReady returns to 1 in the next cycle.
- Back-to-back throughput: one operation per 4 cycles. The block never accepts new operands in DONE.
- All outputs are registered, with no combinational input-to-output paths. The exception is outReady, which is a pure decode of state.

## Configuration
- SUBTRACTOR_SAT_EN:
  - Defined: saturating unsigned mode. When the final borrow is 1, outDiff is forced to 0x00000000 and outBorrow still reports 1. Saturation applies at the HIGH-state register update. Latency is unchanged.
  - Undefined: wrap-around mode. outDiff is always the mod-2^32 difference.

## Test plan
- Reset: assert rst_n=0 mid-HIGH with inValid=1 → immediately state=IDLE, outValid=0, outDiff=0, outBorrow=0. After release, no stale result appears.
- Basic: inA=5, inB=3, inBorrow=0, accepted at E0 → outValid at E0+2, outDiff=0x00000002, outBorrow=0.
- Cross-slice borrow: inA=0x00010000, inB=0x00000001 → outDiff=0x0000FFFF, outBorrow=0. Also inA=0, inB=0, inBorrow=1 → outDiff=0xFFFFFFFF, outBorrow=1.
- Underflow: inA=0, inB=1 → wrap mode gives outDiff=0xFFFFFFFF, outBorrow=1; with SUBTRACTOR_SAT_EN, outDiff=0x00000000, outBorrow=1.
- Backpressure: hold inReady=0 for 5 cycles in DONE → outValid and outDiff stay stable and outReady=0. Change inA and inB during LOW → result unaffected.
- Throughput: inValid held high with 3 different operand sets and inReady=1 → accepts at cycles 0, 4, 8, with results correct and in order (for example 0xFFFFFFFF−0x7FFFFFFF=0x80000000, borrow 0).
